// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the pipeline WB stage
// and a long-latency unit (LU). LU results are queued in a small FIFO; the pipeline normally
// wins the port, but an LU result that has waited STARVE_MAX cycles forces a one-cycle
// pipeline stall so the FIFO head can be written.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pipe_valid/_reg_write/_rd/_data  WB-stage write request
//   lu_valid/lu_rd/lu_data        LU result offer (held until accepted)
//   lu_ready                      FIFO has room (registered count only)
//   stall_pipe                    pipeline must hold WB contents this cycle
//   rf_we/rf_rd/rf_wdata          register-file write port
//   fifo_count                    buffered LU results, for the hazard unit
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RA_W       = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned CntW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_valid,
  input  logic              pipe_reg_write,
  input  logic [RA_W-1:0]   pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lu_valid,
  input  logic [RA_W-1:0]   lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              stall_pipe,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CntW-1:0]   fifo_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned StW  = $clog2(STARVE_MAX + 1);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(DEPTH);
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_MAX);

  logic [RA_W-1:0]   rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            pipe_need, lu_grant, push, pop;

  always_comb begin
    pipe_need = pipe_valid & pipe_reg_write & (pipe_rd != '0);
    // Outputs are forced low while rst is held, even before the flushing edge.
    lu_grant  = !rst && (count_q != '0) && (!pipe_need || (starve_q == StarveMax));
    lu_ready  = !rst && (count_q < DepthCnt);
    // Results for x0 complete the handshake but are never stored.
    push      = lu_valid & lu_ready & (lu_rd != '0);
    pop       = lu_grant;

    rf_we      = 1'b0;
    rf_rd      = '0;
    rf_wdata   = '0;
    stall_pipe = lu_grant & pipe_need;
    fifo_count = rst ? '0 : count_q;

    if (lu_grant) begin
      rf_we    = 1'b1;
      rf_rd    = rd_mem[head_q];
      rf_wdata = data_mem[head_q];
    end else if (!rst && pipe_need) begin
      rf_we    = 1'b1;
      rf_rd    = pipe_rd;
      rf_wdata = pipe_data;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (pop) head_d = (head_q == LastPtr) ? '0 : head_q + PtrW'(1);
    if (push) tail_d = (tail_q == LastPtr) ? '0 : tail_q + PtrW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    if ((count_d == '0) || lu_grant) begin
      starve_d = '0;
    end else if (starve_q == StarveMax) begin
      starve_d = starve_q;
    end else if (count_q != '0) begin
      // A result pushed into an empty FIFO starts waiting from the next cycle.
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset; push is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail_q]   <= lu_rd;
      data_mem[tail_q] <= lu_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DATA_W     = 32;
  localparam int RA_W       = 5;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_valid, pipe_reg_write;
  logic [RA_W-1:0]   pipe_rd;
  logic [DATA_W-1:0] pipe_data;
  logic              lu_valid;
  logic [RA_W-1:0]   lu_rd;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready, stall_pipe, rf_we;
  logic [RA_W-1:0]   rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  fifo_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W(DATA_W), .RA_W(RA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_reg_write(pipe_reg_write),
    .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
    .lu_ready(lu_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  // Reference model: a queue of pending LU results plus a wait counter.
  typedef struct packed {
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t q[$];
  int     starve = 0;
  bit     grant_e, ready_e, need_e, stall_e;
  bit     acc_q = 1'b0, stall_q = 1'b0;
  int     vectors = 0, miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic pv, input logic pw, input logic [RA_W-1:0] prd,
                       input logic [DATA_W-1:0] pd, input logic lv, input logic [RA_W-1:0] lrd,
                       input logic [DATA_W-1:0] ld);
    rst = r; pipe_valid = pv; pipe_reg_write = pw; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
  endtask

  // Compare every output against the model, away from the active edge.
  task automatic sample();
    logic              we_e;
    logic [RA_W-1:0]   rd_e;
    logic [DATA_W-1:0] wd_e;
    @(negedge clk);
    need_e  = pipe_valid && pipe_reg_write && (pipe_rd != 0);
    grant_e = !rst && (q.size() != 0) && (!need_e || starve == STARVE_MAX);
    ready_e = !rst && (q.size() < DEPTH);
    stall_e = grant_e && need_e;
    we_e = 1'b0; rd_e = '0; wd_e = '0;
    if (grant_e) begin
      we_e = 1'b1; rd_e = q[0].rd; wd_e = q[0].data;
    end else if (!rst && need_e) begin
      we_e = 1'b1; rd_e = pipe_rd; wd_e = pipe_data;
    end
    check_eq("rf_we", 64'(rf_we), 64'(we_e));
    check_eq("rf_rd", 64'(rf_rd), 64'(rd_e));
    check_eq("rf_wdata", 64'(rf_wdata), 64'(wd_e));
    check_eq("stall_pipe", 64'(stall_pipe), 64'(stall_e));
    check_eq("lu_ready", 64'(lu_ready), 64'(ready_e));
    check_eq("fifo_count", 64'(fifo_count), rst ? 64'd0 : 64'(q.size()));
  endtask

  task automatic advance();
    int     old;
    entry_t e;
    @(posedge clk);
    old = q.size();
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      if (grant_e) void'(q.pop_front());
      if (lu_valid && ready_e && lu_rd != 0) begin
        e.rd = lu_rd; e.data = lu_data;
        q.push_back(e);
      end
      if (q.size() == 0 || grant_e) starve = 0;
      else if (starve == STARVE_MAX) starve = starve;
      else if (old != 0) starve++;
    end
    acc_q   = lu_valid && ready_e;
    stall_q = stall_e;
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check_eq("rst_we", 64'(rf_we), 64'd0);
    advance();
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Pipe-only write is passed straight through.
    drive(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    sample();
    check_eq("t1_we", 64'(rf_we), 64'd1);
    check_eq("t1_rd", 64'(rf_rd), 64'd5);
    check_eq("t1_data", 64'(rf_wdata), 64'hDEADBEEF);
    check_eq("t1_stall", 64'(stall_pipe), 64'd0);
    advance();

    // LU result to an idle port, written one cycle after acceptance.
    drive(0, 0, 0, 0, 0, 1, 7, 32'h1234);
    sample();
    check_eq("t2_ready", 64'(lu_ready), 64'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check_eq("t2_rd", 64'(rf_rd), 64'd7);
    check_eq("t2_data", 64'(rf_wdata), 64'h1234);
    check_eq("t2_cnt1", 64'(fifo_count), 64'd1);
    advance();
    sample();
    check_eq("t2_cnt0", 64'(fifo_count), 64'd0);
    advance();

    // Starvation: pipe busy every cycle, LU forced in on cycle 5.
    drive(0, 1, 1, 3, 32'hAAAA, 1, 11, 32'h55);
    cyc();
    drive(0, 1, 1, 3, 32'hAAAA, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      sample();
      check_eq($sformatf("t3_stall%0d", i), 64'(stall_pipe), (i == 5) ? 64'd1 : 64'd0);
      check_eq($sformatf("t3_rd%0d", i), 64'(rf_rd), (i == 5) ? 64'd11 : 64'd3);
      advance();
    end

    // FIFO full: third offer held until after the forced pop.
    drive(0, 1, 1, 3, 32'hAAAA, 1, 12, 32'hA0);
    cyc();
    drive(0, 1, 1, 3, 32'hAAAA, 1, 13, 32'hB0);
    cyc();
    drive(0, 1, 1, 3, 32'hAAAA, 1, 14, 32'hC0);
    for (int i = 2; i <= 6; i++) begin
      sample();
      check_eq($sformatf("t4_ready%0d", i), 64'(lu_ready), (i == 6) ? 64'd1 : 64'd0);
      if (i == 5) begin
        check_eq("t4_stall", 64'(stall_pipe), 64'd1);
        check_eq("t4_rdA", 64'(rf_rd), 64'd12);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check_eq("t4_rdB", 64'(rf_rd), 64'd13);
    advance();
    sample();
    check_eq("t4_rdC", 64'(rf_rd), 64'd14);
    advance();
    sample();
    check_eq("t4_cnt", 64'(fifo_count), 64'd0);
    advance();

    // x0 handling on both sides.
    drive(0, 0, 0, 0, 0, 1, 9, 32'h99);
    cyc();
    drive(0, 1, 1, 0, 32'h77, 0, 0, 0);
    sample();
    check_eq("t5_rd", 64'(rf_rd), 64'd9);
    check_eq("t5_data", 64'(rf_wdata), 64'h99);
    check_eq("t5_stall", 64'(stall_pipe), 64'd0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0, 32'h66);
    sample();
    check_eq("t5_ready", 64'(lu_ready), 64'd1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    check_eq("t5_cnt", 64'(fifo_count), 64'd0);
    check_eq("t5_we", 64'(rf_we), 64'd0);
    advance();

    // Reset with two results buffered and the wait counter at 3.
    drive(0, 1, 1, 3, 32'hAAAA, 1, 20, 32'hD0);
    cyc();
    drive(0, 1, 1, 3, 32'hAAAA, 1, 21, 32'hE0);
    cyc();
    drive(0, 1, 1, 3, 32'hAAAA, 0, 0, 0);
    cyc();
    cyc();
    drive(1, 1, 1, 3, 32'hAAAA, 1, 22, 32'hF0);
    sample();
    check_eq("t6_we", 64'(rf_we), 64'd0);
    check_eq("t6_ready", 64'(lu_ready), 64'd0);
    check_eq("t6_cnt", 64'(fifo_count), 64'd0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("t6_post_ready", 64'(lu_ready), 64'd1);
      check_eq("t6_post_we", 64'(rf_we), 64'd0);
      advance();
    end

    // Randomised traffic; offers held until accepted, stalled WB contents held.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!stall_q) begin
        pipe_valid     = ($urandom_range(0, 9) < 7);
        pipe_reg_write = ($urandom_range(0, 9) < 8);
        pipe_rd        = RA_W'($urandom_range(0, 7));
        pipe_data      = $urandom;
      end
      if (!(lu_valid && !acc_q)) begin
        lu_valid = ($urandom_range(0, 9) < 5);
        lu_rd    = RA_W'($urandom_range(0, 7));
        lu_data  = $urandom;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
